// File: rtl/motoro3_hall_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : motoro3_hall_decoder
// Description : Receive side of the 3-phase motor interface. Synchronizes and
//               debounces the three Hall sensors, decodes the commutation step
//               (0..5), the rotation direction and the step period, and flags
//               sequence, invalid-code and stall conditions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock, all logic on posedge
//   nRst         in   1      asynchronous active-low reset
//   hA,hB,hC     in   1      raw asynchronous Hall inputs
//   m3hallStep   out  3      decoded step 0..5, holds last valid value
//   m3hallValid  out  1      accepted code is a valid step code
//   m3hallErr    out  1      accepted code is 000 or 111
//   m3dir        out  1      1 = forward (step+1), 0 = reverse (step-1)
//   m3period     out  CNT_W  cycles between the last two same-direction edges
//   m3periodVld  out  1      one-cycle pulse when m3period updates
//   m3stepErr    out  1      one-cycle pulse on a non-adjacent step jump
//   m3stall      out  1      no motion proven
// ============================================================================
module motoro3_hall_decoder #(
  parameter int DEB_CYC   = 8,
  parameter int CNT_W     = 22,
  parameter int STALL_CYC = 3000000
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             hA,
  input  logic             hB,
  input  logic             hC,
  output logic [2:0]       m3hallStep,
  output logic             m3hallValid,
  output logic             m3hallErr,
  output logic             m3dir,
  output logic [CNT_W-1:0] m3period,
  output logic             m3periodVld,
  output logic             m3stepErr,
  output logic             m3stall
);

  localparam int               c_deb_w = $clog2(DEB_CYC + 1);
  localparam logic [c_deb_w-1:0] c_deb = c_deb_w'(DEB_CYC);
  localparam logic [CNT_W-1:0] c_stall = CNT_W'(STALL_CYC);

  // {valid, step}; 000 and 111 decode as invalid
  function automatic logic [3:0] f_decode(input logic [2:0] code);
    case (code)
      3'b100:  f_decode = {1'b1, 3'd0};
      3'b110:  f_decode = {1'b1, 3'd1};
      3'b010:  f_decode = {1'b1, 3'd2};
      3'b011:  f_decode = {1'b1, 3'd3};
      3'b001:  f_decode = {1'b1, 3'd4};
      3'b101:  f_decode = {1'b1, 3'd5};
      default: f_decode = 4'b0000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Two-flop synchronizer
  // --------------------------------------------------------------------------
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {hA, hB, hC};
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: the candidate is accepted once it has been stable for DEB_CYC
  // cycles. The stability count saturates at DEB_CYC, so an accepted code
  // cannot re-trigger an accept event.
  // --------------------------------------------------------------------------
  logic [2:0]         r_cand;
  logic [2:0]         r_acc;
  logic [c_deb_w-1:0] r_deb;
  logic               w_accept;

  assign w_accept = (r_deb == c_deb) && (r_cand != r_acc);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cand <= '0;
      r_acc  <= '0;
      r_deb  <= '0;
    end else begin
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_deb  <= c_deb_w'(1);
      end else if (r_deb != c_deb) begin
        r_deb <= r_deb + 1'b1;
      end
      if (w_accept) begin
        r_acc <= r_cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accept-event classification against the previous valid step
  // --------------------------------------------------------------------------
  logic [3:0] w_new_dec;
  logic [3:0] w_prev_dec;
  logic [2:0] w_step_inc;
  logic [2:0] w_step_dec;
  logic       w_fwd;
  logic       w_rev;

  assign w_new_dec  = f_decode(r_cand);
  assign w_prev_dec = f_decode(r_acc);
  assign w_step_inc = (m3hallStep == 3'd5) ? 3'd0 : m3hallStep + 3'd1;
  assign w_step_dec = (m3hallStep == 3'd0) ? 3'd5 : m3hallStep - 3'd1;
  assign w_fwd      = (w_new_dec[2:0] == w_step_inc);
  assign w_rev      = (w_new_dec[2:0] == w_step_dec);

  // --------------------------------------------------------------------------
  // Step / direction / period / stall tracking
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m3hallStep  <= '0;
      m3hallValid <= 1'b0;
      m3hallErr   <= 1'b0;
      m3dir       <= 1'b0;
      m3period    <= '0;
      m3periodVld <= 1'b0;
      m3stepErr   <= 1'b0;
      m3stall     <= 1'b1;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
    end else begin
      m3periodVld <= 1'b0;
      m3stepErr   <= 1'b0;

      if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Stall is evaluated first so that a sequential edge on the same cycle
      // (assigned below) overrides it.
      if (r_cnt == c_stall) begin
        m3stall <= 1'b1;
        r_armed <= 1'b0;
      end

      if (w_accept) begin
        if (!w_new_dec[3]) begin
          m3hallValid <= 1'b0;
          m3hallErr   <= 1'b1;
          r_armed     <= 1'b0;
        end else if (!w_prev_dec[3]) begin
          m3hallStep  <= w_new_dec[2:0];
          m3hallValid <= 1'b1;
          m3hallErr   <= 1'b0;
          r_armed     <= 1'b0;
        end else if (w_fwd || w_rev) begin
          m3hallStep <= w_new_dec[2:0];
          m3dir      <= w_fwd;
          m3stall    <= 1'b0;
          r_cnt      <= CNT_W'(1);
          // A period is only meaningful between two edges in the same
          // direction with no stall or jump in between.
          if (r_armed && (w_fwd == m3dir)) begin
            m3period    <= r_cnt;
            m3periodVld <= 1'b1;
          end
          r_armed <= 1'b1;
        end else begin
          m3hallStep <= w_new_dec[2:0];
          m3stepErr  <= 1'b1;
          r_cnt      <= CNT_W'(1);
          r_armed    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motoro3_hall_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_motoro3_hall_decoder
// Description : Randomized scoreboard bench for motoro3_hall_decoder. The
//               stimulus side predicts each observable output change (value
//               and cycle) from the decoder rules and queues it; a monitor
//               pops an entry whenever the outputs change or pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motoro3_hall_decoder;

  localparam int DEB   = 8;
  localparam int W     = 16;
  localparam int STALL = 600;

  localparam logic [2:0] c_seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  typedef struct packed {
    logic [2:0]   step;
    logic         valid;
    logic         err;
    logic         dir;
    logic [W-1:0] period;
    logic         pvld;
    logic         serr;
    logic         stall;
  } obs_t;

  logic         clk = 1'b0;
  logic         nRst = 1'b1;
  logic         hA = 1'b0, hB = 1'b0, hC = 1'b0;
  logic [2:0]   m3hallStep;
  logic         m3hallValid, m3hallErr, m3dir, m3periodVld, m3stepErr, m3stall;
  logic [W-1:0] m3period;

  motoro3_hall_decoder #(.DEB_CYC(DEB), .CNT_W(W), .STALL_CYC(STALL)) dut (
    .clk(clk), .nRst(nRst), .hA(hA), .hB(hB), .hC(hC),
    .m3hallStep(m3hallStep), .m3hallValid(m3hallValid), .m3hallErr(m3hallErr),
    .m3dir(m3dir), .m3period(m3period), .m3periodVld(m3periodVld),
    .m3stepErr(m3stepErr), .m3stall(m3stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t q_obs[$];
  int   q_t[$];

  function automatic obs_t f_rst();
    obs_t o;
    o = '0;
    o.stall = 1'b1;
    return o;
  endfunction

  function automatic obs_t f_steady(input obs_t o);
    obs_t s;
    s = o;
    s.pvld = 1'b0;
    s.serr = 1'b0;
    return s;
  endfunction

  function automatic string f_str(input obs_t o);
    return $sformatf("step=%0d vld=%0d err=%0d dir=%0d per=%0d pv=%0d serr=%0d stall=%0d",
                     o.step, o.valid, o.err, o.dir, o.period, o.pvld, o.serr, o.stall);
  endfunction

  function automatic int f_idx(input logic [2:0] c);
    int r;
    r = -1;
    for (int i = 0; i < 6; i++) if (c_seq[i] == c) r = i;
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: event-level view of the decoder
  // --------------------------------------------------------------------------
  logic [2:0] m_code;
  obs_t       m_obs;
  bit         m_armed;
  bit         m_pend;
  int         m_restart;

  task automatic model_reset();
    m_code  = 3'b000;
    m_obs   = f_rst();
    m_armed = 1'b0;
    m_pend  = 1'b0;
    m_restart = 0;
  endtask

  task automatic push(input obs_t o, input int t);
    q_obs.push_back(o);
    q_t.push_back(t);
  endtask

  task automatic stall_fire(input int t);
    m_pend  = 1'b0;
    m_armed = 1'b0;
    if (!m_obs.stall) begin
      m_obs.stall = 1'b1;
      push(m_obs, t);
    end
  endtask

  // Called every stimulus cycle so that a stall is predicted before it shows.
  task automatic model_tick();
    if (m_pend && (m_restart + STALL <= cyc + 1)) stall_fire(m_restart + STALL);
  endtask

  task automatic model_event(input logic [2:0] code, input int t);
    int   ni, pi;
    bit   seq, fwd;
    obs_t o;
    ni  = f_idx(code);
    pi  = f_idx(m_code);
    fwd = (ni >= 0) && (pi >= 0) && (ni == (pi + 1) % 6);
    seq = fwd || ((ni >= 0) && (pi >= 0) && (ni == (pi + 5) % 6));
    if (m_pend && (m_restart + STALL < t)) stall_fire(m_restart + STALL);
    o = m_obs;
    if (m_pend && (m_restart + STALL == t) && !seq) begin
      m_pend  = 1'b0;
      m_armed = 1'b0;
      o.stall = 1'b1;
    end
    if (ni < 0) begin
      o.valid = 1'b0;
      o.err   = 1'b1;
      m_armed = 1'b0;
    end else if (pi < 0) begin
      o.step  = 3'(ni);
      o.valid = 1'b1;
      o.err   = 1'b0;
      m_armed = 1'b0;
    end else if (seq) begin
      if (m_armed && (fwd == o.dir)) begin
        o.period = W'(t - m_restart);
        o.pvld   = 1'b1;
      end
      o.step    = 3'(ni);
      o.dir     = fwd;
      o.stall   = 1'b0;
      m_armed   = 1'b1;
      m_restart = t;
      m_pend    = 1'b1;
    end else begin
      o.step    = 3'(ni);
      o.serr    = 1'b1;
      m_armed   = 1'b0;
      m_restart = t;
      m_pend    = 1'b1;
    end
    if (o != m_obs) push(o, t);
    m_obs  = f_steady(o);
    m_code = code;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  obs_t r_prev = '0;

  always @(negedge clk) begin
    obs_t cur, e;
    int   t;
    cur = {m3hallStep, m3hallValid, m3hallErr, m3dir, m3period, m3periodVld, m3stepErr, m3stall};
    if (!nRst) begin
      n_vec++;
      if (cur != f_rst()) begin
        n_err++;
        $display("FAIL reset_state @%0d: got %s, want %s", cyc, f_str(cur), f_str(f_rst()));
      end
      r_prev = f_steady(cur);
    end else if ((f_steady(cur) != r_prev) || cur.pvld || cur.serr) begin
      n_vec++;
      if (q_obs.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change @%0d: got %s, want no change", cyc, f_str(cur));
      end else begin
        e = q_obs.pop_front();
        t = q_t.pop_front();
        if ((cur != e) || (cyc != t)) begin
          n_err++;
          $display("FAIL output_event: got %s @%0d, want %s @%0d", f_str(cur), cyc, f_str(e), t);
        end
      end
      r_prev = f_steady(cur);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus (all tasks entered and left just after a falling edge)
  // --------------------------------------------------------------------------
  logic [2:0] pins = 3'b000;

  task automatic drive(input logic [2:0] c);
    pins = c;
    {hA, hB, hC} = c;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      model_tick();
    end
  endtask

  task automatic seg(input logic [2:0] code, input int hold);
    int g, off, b;
    logic [2:0] keep;
    if (code != pins) begin
      drive(code);
      model_event(code, cyc + DEB + 3);
    end
    if ((hold >= 3 * DEB + 10) && ($urandom_range(0, 3) == 0)) begin
      g    = $urandom_range(1, DEB - 1);
      off  = $urandom_range(DEB + 4, hold - g - DEB - 4);
      b    = $urandom_range(0, 2);
      keep = pins;
      wait_cyc(off);
      {hA, hB, hC} = keep ^ (3'b001 << b);
      wait_cyc(g);
      {hA, hB, hC} = keep;
      wait_cyc(hold - off - g);
    end else begin
      wait_cyc(hold);
    end
  endtask

  task automatic reset_and_release(input logic [2:0] code);
    @(posedge clk);
    #2 nRst = 1'b0;
    model_reset();
    repeat (12) begin
      @(negedge clk);
      drive(3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    drive(code);
    nRst = 1'b1;
    model_event(code, cyc + DEB + 3);
  endtask

  task automatic settle_and_drain();
    int k;
    wait_cyc(STALL + DEB + 20);
    k = 0;
    while ((q_obs.size() != 0) && (k < 200)) begin
      wait_cyc(1);
      k++;
    end
    if (q_obs.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d expected events not observed, want 0", q_obs.size());
      q_obs.delete();
      q_t.delete();
    end
  endtask

  task automatic random_run(input int n);
    int         r, pi, hold;
    logic [2:0] nc;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 99);
      pi = f_idx(pins);
      if (pi < 0)       nc = c_seq[$urandom_range(0, 5)];
      else if (r < 40)  nc = c_seq[(pi + 1) % 6];
      else if (r < 68)  nc = c_seq[(pi + 5) % 6];
      else if (r < 80)  nc = c_seq[(pi + 2 + $urandom_range(0, 2)) % 6];
      else if (r < 90)  nc = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b111;
      else              nc = c_seq[$urandom_range(0, 5)];
      hold = ($urandom_range(0, 11) == 0) ? STALL + $urandom_range(0, 50)
                                          : $urandom_range(DEB + 4, 260);
      seg(nc, hold);
    end
  endtask

  localparam logic [2:0] c_dcode [19] = '{
    3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100,   // forward revolution
    3'b101, 3'b001,                                   // reversal
    3'b011, 3'b100,                                   // reverse step, then jump
    3'b110, 3'b010,                                   // re-arm after jump
    3'b011, 3'b001,                                   // edge exactly at stall count
    3'b101, 3'b100,                                   // stall one cycle before edge
    3'b110, 3'b111, 3'b110                            // stall, invalid, resync
  };
  localparam int c_dhold [19] = '{
    300, 300, 300, 300, 300, 300,
    150, 150, 150, 150, 150, 150,
    STALL, STALL + 1, 200, 200,
    STALL + 50, 100, 100
  };

  initial begin
    model_reset();
    #1 nRst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      drive(3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    drive(3'b100);
    nRst = 1'b1;
    model_event(3'b100, cyc + DEB + 3);
    wait_cyc(300);

    for (int i = 0; i < 19; i++) seg(c_dcode[i], c_dhold[i]);
    settle_and_drain();

    random_run(120);
    settle_and_drain();

    reset_and_release(c_seq[$urandom_range(0, 5)]);
    wait_cyc(200);
    random_run(60);
    settle_and_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
